// File: rtl/fp_mul_sched.sv
// fp_mul_sched: round-robin scheduler that shares one pipelined
// single-precision multiplier among NREQ requesters.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester valid/grant. A transfer happens in any
//                       cycle where both are high for the same requester.
//                       req_ready is combinational, one-hot, and depends on
//                       req_valid. There is no backpressure on responses.
//   req_x/req_y         packed operands, requester i at [32i+31:32i]
//   req_rmode           packed rounding modes, requester i at [3i+2:3i]
//   flush               drops every in-flight operation and blocks issue
//   mul_x/mul_y/mul_rmode  registered operands to the multiplier
//   mul_z/mul_ovrf/mul_udrf  multiplier result, valid MUL_LAT cycles after issue
//   rsp_valid           one-cycle pulse to the owning requester
//   rsp_z/rsp_ovrf/rsp_udrf/rsp_err  shared result bus, held between pulses
//   in_flight           operations accepted but not yet answered
module fp_mul_sched #(
    parameter int NREQ    = 2,
    parameter int MUL_LAT = 3,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [32*NREQ-1:0]   req_y,
    input  logic [3*NREQ-1:0]    req_rmode,
    input  logic                 flush,
    output logic [31:0]          mul_x,
    output logic [31:0]          mul_y,
    output logic [2:0]           mul_rmode,
    input  logic [31:0]          mul_z,
    input  logic                 mul_ovrf,
    input  logic                 mul_udrf,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_z,
    output logic                 rsp_ovrf,
    output logic                 rsp_udrf,
    output logic                 rsp_err,
    output logic [3:0]           in_flight
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] shifted;
    logic [IDW-1:0]  gnt_id;
    logic            found;
    logic            hs;
    logic [31:0]     sel_x;
    logic [31:0]     sel_y;
    logic [2:0]      sel_rmode;
    logic            sel_err;
    logic            rsp_any;

    // Registered tag stages 1..MUL_LAT; stage 0 is the live issue tag.
    // The last entry lines up with mul_z for the operands it describes.
    logic            tag_v   [MUL_LAT];
    logic [IDW-1:0]  tag_id  [MUL_LAT];
    logic            tag_err [MUL_LAT];

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        found   = 1'b0;
        shifted = '0;
        for (int k = 0; k < NREQ; k++) begin
            shifted = req_valid >> ((int'(ptr) + k) % NREQ);
            if (!found && shifted[0]) begin
                found  = 1'b1;
                gnt_id = IDW'((int'(ptr) + k) % NREQ);
                grant  = NREQ'(1) << ((int'(ptr) + k) % NREQ);
            end
        end
    end

    // Reset is folded in so every output reads 0 while rst_n is low.
    assign req_ready = (flush || !rst_n) ? '0 : grant;
    assign hs        = |req_ready;

    assign sel_x     = 32'(req_x >> (32 * int'(gnt_id)));
    assign sel_y     = 32'(req_y >> (32 * int'(gnt_id)));
    assign sel_rmode = 3'(req_rmode >> (3 * int'(gnt_id)));
    assign sel_err   = (sel_rmode > 3'd4);
    assign rsp_any   = |rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            mul_x     <= '0;
            mul_y     <= '0;
            mul_rmode <= '0;
        end else if (hs) begin
            ptr       <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
            mul_x     <= sel_x;
            mul_y     <= sel_y;
            // An illegal mode still issues, but with RNE so the multiplier
            // sees a defined mode; the tag err bit replaces the result.
            mul_rmode <= sel_err ? 3'b000 : sel_rmode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_v[i]   <= 1'b0;
                tag_id[i]  <= '0;
                tag_err[i] <= 1'b0;
            end
        end else begin
            tag_v[0]   <= hs && !flush;
            tag_id[0]  <= gnt_id;
            tag_err[0] <= sel_err;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1] && !flush;
                tag_id[i]  <= tag_id[i-1];
                tag_err[i] <= tag_err[i-1];
            end
        end
    end

    // mul_z is only captured when the aligned tag is valid, so whatever the
    // multiplier produces on idle cycles never reaches the response bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_z     <= '0;
            rsp_ovrf  <= 1'b0;
            rsp_udrf  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (tag_v[MUL_LAT-1] && !flush) begin
                rsp_valid <= NREQ'(1) << tag_id[MUL_LAT-1];
                rsp_z     <= tag_err[MUL_LAT-1] ? QNAN : mul_z;
                rsp_ovrf  <= tag_err[MUL_LAT-1] ? 1'b0 : mul_ovrf;
                rsp_udrf  <= tag_err[MUL_LAT-1] ? 1'b0 : mul_udrf;
                rsp_err   <= tag_err[MUL_LAT-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else if (flush) begin
            in_flight <= '0;
        end else if (hs && !rsp_any) begin
            in_flight <= in_flight + 4'd1;
        end else if (!hs && rsp_any) begin
            in_flight <= in_flight - 4'd1;
        end
    end

endmodule

// File: tb/tb_fp_mul_sched.sv
module tb_fp_mul_sched;

    localparam int NREQ    = 2;
    localparam int MUL_LAT = 3;
    localparam int IDW     = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_x;
    logic [32*NREQ-1:0]  req_y;
    logic [3*NREQ-1:0]   req_rmode;
    logic                flush;
    logic [31:0]         mul_x;
    logic [31:0]         mul_y;
    logic [2:0]          mul_rmode;
    logic [31:0]         mul_z;
    logic                mul_ovrf;
    logic                mul_udrf;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_z;
    logic                rsp_ovrf;
    logic                rsp_udrf;
    logic                rsp_err;
    logic [3:0]          in_flight;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [NREQ-1:0] rv;
        logic [31:0]     z;
        logic            ovrf;
        logic            udrf;
        logic            err;
        logic [31:0]     t;
    } exp_t;

    exp_t exp_q[$];

    fp_mul_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_rmode(req_rmode),
        .flush(flush),
        .mul_x(mul_x), .mul_y(mul_y), .mul_rmode(mul_rmode),
        .mul_z(mul_z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
        .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_ovrf(rsp_ovrf),
        .rsp_udrf(rsp_udrf), .rsp_err(rsp_err), .in_flight(in_flight)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- multiplier model ----------------
    // Truncating product for normal operands: enough to give every op a
    // distinct, independently computable result.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        logic [22:0] f;
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (m[47]) begin
            f = m[46:24];
            e = e + 10'd1;
        end else begin
            f = m[45:23];
        end
        return {a[31] ^ b[31], e[7:0], f};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    // Operands seen in cycle T+1 give a result in cycle T+MUL_LAT.
    logic [33:0] mpipe [MUL_LAT-1];
    always @(posedge clk) begin
        mpipe[0] <= {fmul(mul_x, mul_y), ^mul_rmode, mul_x[0] ^ mul_y[0]};
        for (int i = 1; i < MUL_LAT - 1; i++) mpipe[i] <= mpipe[i-1];
    end
    assign {mul_z, mul_ovrf, mul_udrf} = mpipe[MUL_LAT-2];

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (rsp_valid !== '0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_rsp: rsp_valid=%b z=%h, required no response", rsp_valid, rsp_z);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({rsp_valid, rsp_z, rsp_ovrf, rsp_udrf, rsp_err} !== {e.rv, e.z, e.ovrf, e.udrf, e.err})
                        $display("FAIL rsp_data: got v=%b z=%h o=%b u=%b e=%b, required v=%b z=%h o=%b u=%b e=%b",
                                 rsp_valid, rsp_z, rsp_ovrf, rsp_udrf, rsp_err, e.rv, e.z, e.ovrf, e.udrf, e.err);
                    else n_pass++;
                    n_checks++;
                    if (cyc !== int'(e.t) + MUL_LAT + 1)
                        $display("FAIL rsp_latency: response in cycle %0d, required %0d", cyc, int'(e.t) + MUL_LAT + 1);
                    else n_pass++;
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if ((req_valid & req_ready) != '0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        exp_t e;
                        logic [31:0] x, y;
                        logic [2:0]  rm;
                        x = req_x[32*i +: 32];
                        y = req_y[32*i +: 32];
                        rm = req_rmode[3*i +: 3];
                        e.rv   = NREQ'(1) << i;
                        e.err  = (rm > 3'd4);
                        e.z    = e.err ? 32'h7FC0_0000 : fmul(x, y);
                        e.ovrf = e.err ? 1'b0 : ^rm;
                        e.udrf = e.err ? 1'b0 : (x[0] ^ y[0]);
                        e.t    = 32'(cyc);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        flush     = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
        req_valid[i]       = 1'b1;
        req_x[32*i +: 32]  = x;
        req_y[32*i +: 32]  = y;
        req_rmode[3*i +: 3] = rm;
    endtask

    task automatic drain();
        for (int k = 0; k < 30; k++) begin
            if (exp_q.size() == 0) break;
            tick();
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        req_x = '0;
        req_y = '0;
        req_rmode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({mul_x, mul_y, mul_rmode, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf, rsp_err, in_flight, req_ready} !== '0)
            $display("FAIL reset_outputs: mul_x=%h mul_y=%h rsp_valid=%b rsp_z=%h in_flight=%0d, required all 0",
                     mul_x, mul_y, rsp_valid, rsp_z, in_flight);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        tick();
        set_req(0, 32'h4000_0000, 32'h4040_0000, 3'b000);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL single_grant: req_ready=%b, required 01", req_ready);
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if (mul_x !== 32'h4000_0000 || mul_y !== 32'h4040_0000)
            $display("FAIL single_operands: mul_x=%h mul_y=%h, required 40000000 40400000", mul_x, mul_y);
        else n_pass++;
        n_checks++;
        if (in_flight !== 4'd1) $display("FAIL single_inflight1: in_flight=%0d, required 1", in_flight);
        else n_pass++;
        for (int k = 2; k <= 5; k++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (in_flight !== ((k <= 4) ? 4'd1 : 4'd0))
                $display("FAIL single_inflight: step %0d in_flight=%0d, required %0d", k, in_flight, (k <= 4) ? 1 : 0);
            else n_pass++;
            if (k == 4) begin
                n_checks++;
                if (rsp_valid !== 2'b01 || rsp_z !== 32'h40C0_0000)
                    $display("FAIL single_result: rsp_valid=%b rsp_z=%h, required 01 40c00000", rsp_valid, rsp_z);
                else n_pass++;
            end
        end
    endtask

    task automatic test_fairness();
        // Requester 1 alone brings the pointer back to 0.
        tick();
        set_req(1, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b10) $display("FAIL fair_prelude: req_ready=%b, required 10", req_ready);
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            tick();
            set_req(0, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
            set_req(1, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
            @(negedge clk);
            n_checks++;
            if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL fair_grant: cycle %0d req_ready=%b, required %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            else n_pass++;
        end
        tick();
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        int pulses;
        for (int k = 0; k < 4; k++) begin
            tick();
            set_req(1, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
            @(negedge clk);
            n_checks++;
            if (req_ready !== 2'b10 || in_flight !== 4'(k))
                $display("FAIL b2b_issue: op %0d req_ready=%b in_flight=%0d, required 10 %0d", k, req_ready, in_flight, k);
            else n_pass++;
        end
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if (in_flight !== 4'd4) $display("FAIL b2b_peak: in_flight=%0d, required 4", in_flight);
        else n_pass++;
        pulses = (rsp_valid == 2'b10) ? 1 : 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            @(negedge clk);
            if (rsp_valid == 2'b10) pulses++;
        end
        n_checks++;
        if (pulses !== 4 || in_flight !== 4'd0)
            $display("FAIL b2b_drain: pulses=%0d in_flight=%0d, required 4 0", pulses, in_flight);
        else n_pass++;
    endtask

    task automatic test_illegal();
        tick();
        set_req(0, rand_fp(), rand_fp(), 3'b110);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL illegal_grant: req_ready=%b, required 01", req_ready);
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if (mul_rmode !== 3'b000) $display("FAIL illegal_rmode: mul_rmode=%b, required 000", mul_rmode);
        else n_pass++;
        repeat (MUL_LAT) begin
            tick();
            @(negedge clk);
        end
        n_checks++;
        if (rsp_valid !== 2'b01 || rsp_z !== 32'h7FC0_0000 || rsp_err !== 1'b1)
            $display("FAIL illegal_rsp: rsp_valid=%b rsp_z=%h rsp_err=%b, required 01 7fc00000 1", rsp_valid, rsp_z, rsp_err);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 2'b00 || rsp_z !== 32'h7FC0_0000 || rsp_err !== 1'b1)
            $display("FAIL illegal_hold: rsp_valid=%b rsp_z=%h rsp_err=%b, required 00 7fc00000 1", rsp_valid, rsp_z, rsp_err);
        else n_pass++;
    endtask

    task automatic test_flush();
        int pulses;
        for (int k = 0; k < 3; k++) begin
            tick();
            idle();
            set_req(k % 2, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
        end
        tick();
        req_valid = 2'b01;
        flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b00) $display("FAIL flush_ready: req_ready=%b, required 00", req_ready);
        else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if (in_flight !== 4'd0) $display("FAIL flush_inflight: in_flight=%0d, required 0", in_flight);
        else n_pass++;
        pulses = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            @(negedge clk);
            if (rsp_valid != '0) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL flush_pulses: %0d pulses, required 0", pulses);
        else n_pass++;
        // Last grant before the flush went to 0, so the pointer sits at 1.
        tick();
        set_req(0, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
        set_req(1, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b10) $display("FAIL flush_ptr: req_ready=%b, required 10", req_ready);
        else n_pass++;
        tick();
        idle();
        drain();
    endtask

    task automatic test_async_reset();
        int pulses;
        tick();
        set_req(0, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
        tick();
        idle();
        @(posedge clk);
        #3;
        req_valid = 2'b01;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mul_x, mul_y, mul_rmode, rsp_valid, rsp_z, rsp_err, in_flight, req_ready} !== '0)
            $display("FAIL async_reset: mul_x=%h in_flight=%0d rsp_valid=%b req_ready=%b, required all 0",
                     mul_x, in_flight, rsp_valid, req_ready);
        else n_pass++;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            @(negedge clk);
            if (rsp_valid != '0) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || in_flight !== 4'd0)
            $display("FAIL reset_lost_ops: pulses=%0d in_flight=%0d, required 0 0", pulses, in_flight);
        else n_pass++;
        tick();
        set_req(0, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
        set_req(1, rand_fp(), rand_fp(), 3'($urandom_range(0, 4)));
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL reset_ptr: req_ready=%b, required 01", req_ready);
        else n_pass++;
        tick();
        idle();
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_async_reset();
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
